// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and helpers for the PWM setpoint path
package pwm_pkg;

    localparam int DEF_WIDTH    = 20;
    localparam int DEF_FRACBITS = 4;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]    int_part;
        logic [DEF_FRACBITS-1:0] frac;
    } duty_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

    // Compare value that corresponds to 100 % duty.
    function automatic logic [31:0] cmp_max(input int period, input int hrbits);
        return 32'((period + 1) << hrbits);
    endfunction

endpackage

// File: rtl/pwm_frac_acc.sv
// rtl/pwm_frac_acc.sv - first-order fractional accumulator producing the dither carry
module pwm_frac_acc #(
    parameter int FRACBITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FRACBITS-1:0] frac,
    input  logic                load,
    input  logic                clr,
    output logic                carry,
    output logic [FRACBITS-1:0] acc
);

    logic [FRACBITS-1:0] acc_q;
    logic [FRACBITS:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, frac};
    assign carry = sum[FRACBITS];
    assign acc   = acc_q;

    // clr dominates so a clamped period discards the accumulated phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= sum[FRACBITS-1:0];
        end
    end

endmodule

// File: rtl/pwm_cmp_dither.sv
// rtl/pwm_cmp_dither.sv - buffered, dithered compare setpoint reloaded at each PWM period end
module pwm_cmp_dither
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int HRBITS   = 3,
    parameter int PERIOD   = 'hff,
    parameter int FRACBITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH+FRACBITS-1:0] s_duty,
    input  logic                      prd_end,
    output logic [WIDTH-1:0]          cmpA,
    output logic                      cmp_update,
    output logic                      sat,
    input  logic                      sat_clr
);

    localparam logic [WIDTH:0] CMP_MAX  = (WIDTH+1)'(cmp_max(PERIOD, HRBITS));
    localparam logic [0:0]     ST_IDLE  = IDLE;
    localparam logic [0:0]     ST_RUN   = RUN;

    logic [WIDTH+FRACBITS-1:0] pend_q;
    logic [WIDTH+FRACBITS-1:0] act_q;
    logic [WIDTH+FRACBITS-1:0] word;
    logic                      pend_v;
    logic                      act_v;
    logic [0:0]                state_q;
    logic [WIDTH-1:0]          word_int;
    logic [FRACBITS-1:0]       word_frac;
    logic [FRACBITS-1:0]       acc_unused;
    logic                      carry;
    logic                      do_update;
    logic                      over;
    logic [WIDTH:0]            raw;

    assign s_ready   = !pend_v;
    assign word      = pend_v ? pend_q : act_q;
    assign word_int  = word[WIDTH+FRACBITS-1:FRACBITS];
    assign word_frac = word[FRACBITS-1:0];
    assign do_update = prd_end && (pend_v || (state_q == ST_RUN && act_v));
    assign raw       = {1'b0, word_int} + {{WIDTH{1'b0}}, carry};
    assign over      = raw > CMP_MAX;

    pwm_frac_acc #(
        .FRACBITS (FRACBITS)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .frac  (word_frac),
        .load  (do_update && !over),
        .clr   (do_update && over),
        .carry (carry),
        .acc   (acc_unused)
    );

    // A word accepted on a boundary cycle only lands in pending; it is applied next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_v     <= 1'b0;
            act_q      <= '0;
            act_v      <= 1'b0;
            state_q    <= ST_IDLE;
            cmpA       <= '0;
            cmp_update <= 1'b0;
            sat        <= 1'b0;
        end else begin
            cmp_update <= do_update;
            if (s_valid && !pend_v) begin
                pend_q <= s_duty;
                pend_v <= 1'b1;
            end else if (do_update && pend_v) begin
                pend_v <= 1'b0;
            end
            if (do_update) begin
                if (pend_v) begin
                    act_q   <= pend_q;
                    act_v   <= 1'b1;
                    state_q <= ST_RUN;
                end
                cmpA <= over ? CMP_MAX[WIDTH-1:0] : raw[WIDTH-1:0];
            end
            if (do_update && over) begin
                sat <= 1'b1;
            end else if (sat_clr) begin
                sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_cmp_dither.sv
// tb/tb_pwm_cmp_dither.sv - scoreboard bench for pwm_cmp_dither with directed vectors
module tb_pwm_cmp_dither;
    import pwm_pkg::*;

    localparam int WIDTH    = 20;
    localparam int FRACBITS = 4;

    logic                      clk     = 1'b0;
    logic                      rst_n   = 1'b1;
    logic                      s_valid = 1'b0;
    logic                      prd_end = 1'b0;
    logic                      sat_clr = 1'b0;
    logic [WIDTH+FRACBITS-1:0] s_duty  = '0;
    logic                      s_ready;
    logic                      cmp_update;
    logic                      sat;
    logic [WIDTH-1:0]          cmpA;

    typedef struct {
        logic [WIDTH-1:0] cmp;
        logic             sat;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } dchk_t;

    exp_t   exp_q[$];
    dchk_t  dq[$];
    int     checks  = 0;
    int     errors  = 0;
    longint obs_sum = 0;

    always #5 clk = ~clk;

    pwm_cmp_dither #(
        .WIDTH    (WIDTH),
        .HRBITS   (3),
        .PERIOD   ('hff),
        .FRACBITS (FRACBITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_duty     (s_duty),
        .prd_end    (prd_end),
        .cmpA       (cmpA),
        .cmp_update (cmp_update),
        .sat        (sat),
        .sat_clr    (sat_clr)
    );

    function automatic logic [WIDTH+FRACBITS-1:0] mk(input int i, input int f);
        duty_word_t w;
        w.int_part = i[WIDTH-1:0];
        w.frac     = f[FRACBITS-1:0];
        return w;
    endfunction

    // Single checking process: drains directed samples, then scores any reload.
    always @(negedge clk) begin
        dchk_t d;
        exp_t  e;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            checks++;
            if (d.act !== d.req) begin
                errors++;
                $display("FAIL %s: got %0h want %0h", d.name, d.act, d.req);
            end
        end
        if (rst_n && cmp_update) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: cmpA=%0h sat=%0b with nothing expected", cmpA, sat);
            end else begin
                e = exp_q.pop_front();
                obs_sum += cmpA;
                if (cmpA !== e.cmp || sat !== e.sat) begin
                    errors++;
                    $display("FAIL cmp_reload: cmpA=%0h sat=%0b want cmpA=%0h sat=%0b", cmpA, sat, e.cmp, e.sat);
                end
            end
        end
    end

    task automatic dcheck(input string name, input logic [31:0] act, input logic [31:0] req);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.req  = req;
        dq.push_back(d);
    endtask

    task automatic expect_cmp(input logic [WIDTH-1:0] c, input logic s);
        exp_t e;
        e.cmp = c;
        e.sat = s;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [WIDTH+FRACBITS-1:0] w);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_duty  = w;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) dcheck("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic pulse(input bit upd, input logic [WIDTH-1:0] c, input logic s);
        @(negedge clk);
        prd_end = 1'b1;
        if (upd) expect_cmp(c, s);
        @(negedge clk);
        prd_end = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint base;

        #2 rst_n = 1'b0;
        #1;
        dcheck("rst_cmpA", 32'(cmpA), 32'd0);
        dcheck("rst_s_ready", 32'(s_ready), 32'd1);
        dcheck("rst_sat", 32'(sat), 32'd0);
        dcheck("rst_cmp_update", 32'(cmp_update), 32'd0);
        #20 rst_n = 1'b1;

        pulse(0, '0, 1'b0);
        dcheck("idle_no_update", 32'(cmp_update), 32'd0);

        send(mk(100, 0));
        pulse(1, 20'd100, 1'b0);
        @(negedge clk);
        dcheck("update_one_cycle", 32'(cmp_update), 32'd0);
        repeat (10) pulse(1, 20'd100, 1'b0);

        send(mk(100, 4));
        @(posedge clk);
        base = obs_sum;
        for (int i = 0; i < 16; i++) pulse(1, (i % 4 == 3) ? 20'd101 : 20'd100, 1'b0);
        @(posedge clk);
        dcheck("dither_sum16", 32'(obs_sum - base), 32'd1604);

        send(mk(200, 0));
        @(negedge clk);
        s_valid = 1'b1;
        s_duty  = mk(300, 0);
        dcheck("bp_stall0", 32'(s_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            dcheck("bp_stall", 32'(s_ready), 32'd0);
        end
        pulse(1, 20'd200, 1'b0);
        dcheck("bp_ready_after_prd", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        dcheck("bp_b_taken", 32'(s_ready), 32'd0);
        pulse(1, 20'd300, 1'b0);

        send(mk(50, 0));
        pulse(1, 20'd50, 1'b0);
        @(negedge clk);
        s_valid = 1'b1;
        s_duty  = mk(60, 0);
        prd_end = 1'b1;
        expect_cmp(20'd50, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        prd_end = 1'b0;
        dcheck("same_cycle_pending", 32'(s_ready), 32'd0);
        pulse(1, 20'd60, 1'b0);

        send(mk('h20, 8));
        pulse(1, 20'h20, 1'b0);
        send(mk('h900, 8));
        pulse(1, 20'h800, 1'b1);
        dcheck("sat_acc_cleared", 32'(dut.u_acc.acc), 32'd0);
        send(mk('h10, 12));
        pulse(1, 20'h10, 1'b1);
        pulse(1, 20'h11, 1'b1);
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        dcheck("sat_cleared", 32'(sat), 32'd0);

        send(mk('h7ff, 15));
        pulse(1, 20'h800, 1'b0);
        pulse(1, 20'h800, 1'b0);
        send(mk('h900, 0));
        @(negedge clk);
        prd_end = 1'b1;
        sat_clr = 1'b1;
        expect_cmp(20'h800, 1'b1);
        @(negedge clk);
        prd_end = 1'b0;
        sat_clr = 1'b0;
        dcheck("sat_set_wins", 32'(sat), 32'd1);

        send(mk('h40, 0));
        @(negedge clk);
        prd_end = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        prd_end = 1'b0;
        dcheck("async_rst_cmpA", 32'(cmpA), 32'd0);
        dcheck("async_rst_update", 32'(cmp_update), 32'd0);
        dcheck("async_rst_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;

        send(mk('h41, 0));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        dcheck("async_rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        pulse(0, '0, 1'b0);
        dcheck("rst_discard_pending", 32'(cmp_update), 32'd0);
        dcheck("rst_cmpA_held", 32'(cmpA), 32'd0);

        repeat (3) @(negedge clk);
        dcheck("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_cmp_dither.md
# pwm_cmp_dither

Upstream setpoint stage for the dual-output PWM core. It accepts high-resolution duty words (integer compare value plus fractional bits) over a valid/ready handshake and holds them in a one-deep pending buffer. At each period boundary it delivers a new compare value on `cmpA`, which the PWM core consumes directly. A first-order fractional accumulator dithers the compare LSB across periods, so the average duty resolves below one high-res tick.

## Interface

**Parameters**
- `WIDTH`, default 20: width of `cmpA` (period bits + HRBITS); same meaning as the PWM core.
- `HRBITS`, default 3: high-resolution sub-tick bits.
- `PERIOD`, default 'hff: period register value; the period is PERIOD+1 timebase ticks.
- `FRACBITS`, default 4: fractional dither bits carried in the duty word.

**Ports**
- `clk`, input, 1: single clock, shared with the PWM core.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `s_valid`, input, 1: duty word offered.
- `s_ready`, output, 1: pending buffer empty; transfer occurs when `s_valid && s_ready`.
- `s_duty`, input, WIDTH+FRACBITS: [WIDTH+FRACBITS-1:FRACBITS] is the integer compare; [FRACBITS-1:0] is the fraction.
- `prd_end`, input, 1: one-cycle pulse from the PWM timebase in the cycle where tb == prd, i.e. the last tick of the period.
- `cmpA`, output, WIDTH: compare value to the PWM core. Registered.
- `cmp_update`, output, 1: one-cycle pulse in the cycle after `cmpA` was reloaded.
- `sat`, output, 1: sticky saturation flag.
- `sat_clr`, input, 1: clears `sat`.

## Operation

- Constant `CMP_MAX` = (PERIOD+1) << HRBITS, which is the 100 % duty compare value.
- **Storage**
  - `pend_q` / `pend_v`: pending word and its valid flag.
  - `act_q` / `act_v`: active word and its valid flag.
  - `acc_q`: fractional accumulator, FRACBITS bits.
- `s_ready = !pend_v`. On handshake, `pend_q <= s_duty` and `pend_v <= 1`.
- **FSM states**
  - **IDLE**: entered on reset; `act_v = 0`; `cmpA` is held at 0.
  - **RUN**: entered on the first `prd_end` while `pend_v = 1`. The FSM never leaves RUN except through reset.
- **On `prd_end`**
  - If `pend_v`: `act_q <= pend_q`, `pend_v <= 0`, and the new word is used in the computation below. Otherwise `act_q` is reused.
  - `sum = acc_q + frac(word)`, FRACBITS+1 bits. `carry = sum[FRACBITS]`.
  - `raw = int(word) + carry`, WIDTH+1 bits, so there is no overflow.
  - If `raw > CMP_MAX`: `cmpA <= CMP_MAX`, `acc_q <= 0`, `sat <= 1`. This is anti-windup.
  - Otherwise: `cmpA <= raw[WIDTH-1:0]` and `acc_q <= sum[FRACBITS-1:0]`.
  - In IDLE with `pend_v = 0`: no change, and no `cmp_update`.
- **Boundary conditions**
  - **Handshake and `prd_end` in the same cycle:** the incoming word goes to pending. It is NOT applied this boundary; it applies at the next boundary.
  - **Pending full at `prd_end`:** pending is consumed, and `s_ready` rises in the following cycle.
  - **`sat` set and `sat_clr` in the same cycle:** set wins.
  - **New word loaded:** `acc_q` is not reset; the dither phase carries over.
  - **`rst_n` low mid-operation:** `cmpA`, `acc_q`, `pend_v`, `act_v`, `sat` and `cmp_update` clear immediately. The FSM returns to IDLE and any pending word is discarded.

## Timing

- **Reset values:** `cmpA` = 0, `s_ready` = 1, `cmp_update` = 0, `sat` = 0.
- **`cmpA` reload:** on the clock edge that samples `prd_end` high. This is the same edge on which the PWM timebase wraps to 0, so the new compare covers the entire next period with no mid-period glitch.
- **`cmp_update`:** high for exactly one cycle after that edge.
- **Handshake to effect:** minimum 2 edges, i.e. accept at edge N and `prd_end` sampled at edge N+1 or later.
- **Throughput:** at most one word per PWM period. `s_ready` stays low until the next `prd_end` consumes the pending word.
- **Compute path:** combinational only — one adder of FRACBITS+1 bits, one adder and comparator of WIDTH+1 bits, and a mux — feeding a single register stage.
- **`prd_end` spacing:** assumed ≥ 2 cycles apart, since PERIOD ≥ 1. Back-to-back pulses are still processed independently.

## Structure

- **Package `pwm_pkg`:**
  - `cmp_max(PERIOD, HRBITS)` function.
  - Typedef of the duty word as a packed struct of int and frac fields.
  - FSM state enum {IDLE, RUN}.
- **Sub-module `pwm_frac_acc`:** accumulator register plus carry and saturation logic. Inputs are `frac`, `load`, and `clr`; outputs are `carry` and the accumulator value. The top level holds the handshake buffer, FSM, clamp and output register.

## Test plan

All scenarios use default parameters, so `CMP_MAX` = 'h800.

- **Reset:** assert `rst_n` = 0 asynchronously mid-cycle → `cmpA` = 0, `s_ready` = 1, `sat` = 0, `cmp_update` = 0 immediately. A `prd_end` with nothing pending produces no `cmp_update`.
- **Integer only:** accept int = 100, frac = 0, then pulse `prd_end` → `cmpA` = 100 on that edge and a single `cmp_update` pulse. Ten more `prd_end` pulses keep `cmpA` = 100.
- **Dither:** accept int = 100, frac = 4 (0.25) → successive periods give `cmpA` = 100, 100, 100, 101, repeating. The mean over 16 periods is 100.25.
- **Backpressure:** offer A = 200 and B = 300 back to back with no `prd_end` → A accepted, B stalls with `s_ready` = 0. At `prd_end`: `cmpA` = 200 and B is accepted the next cycle. At the following `prd_end`: `cmpA` = 300.
- **Same-cycle handshake and `prd_end`:** active word = 50; offer 60 on the `prd_end` cycle → `cmpA` stays 50 for that period and becomes 60 at the next `prd_end`.
- **Saturation:** accept int = 'h900 → `cmpA` = 'h800, `sat` = 1, `acc_q` = 0. `sat` persists through later in-range words until `sat_clr`; with `sat_clr` and a saturating `prd_end` in the same cycle, `sat` stays 1.
